// File: rtl/tape_pkg.sv
// ============================================================
// tape_pkg: shared state encoding and default widths
// Rev 1.0
// ============================================================
`default_nettype none

package tape_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================
// rr_arb2: two-way round-robin arbiter, index 0 = core, 1 = host
// Rev 1.0
// ============================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // set when the host port was the most recent winner
    logic r_last_host;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = r_last_host ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_host <= 1'b1;
        end else if (|gnt) begin
            r_last_host <= gnt[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/tape_arbiter.sv
// ============================================================
// tape_arbiter: zeroes a tape RAM and arbitrates core/host access
// Rev 1.0
// ============================================================
`default_nettype none

module tape_arbiter
    import tape_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_clear,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_core_rv;
    logic              r_host_rv;
    logic [1:0]        w_gnt;
    logic              w_idle;
    logic              w_clearing;
    logic              w_last_cell;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_clearing  = (r_state == ST_CLEAR);
    assign w_last_cell = &r_cnt;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (reset),
        .req   ({host_req, core_req}),
        .en    (w_idle),
        .gnt   (w_gnt)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT:  w_next_state = ST_CLEAR;
            ST_CLEAR: if (w_last_cell) w_next_state = ST_IDLE;
            ST_IDLE:  if (start_clear) w_next_state = ST_CLEAR;
            default:  w_next_state = ST_INIT;
        endcase
    end

    // Counter is held at zero outside CLEAR so every clear starts at address 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_INIT;
            r_cnt     <= '0;
            r_core_rv <= 1'b0;
            r_host_rv <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_clearing ? r_cnt + 1'b1 : '0;
            r_core_rv <= w_gnt[0] & ~core_we;
            r_host_rv <= w_gnt[1] & ~host_we;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_cnt;
        mem_wdata = '0;
        if (w_clearing) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
        end else if (w_gnt[1]) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (w_gnt[0]) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    assign clear_busy  = ~w_idle;
    assign clear_done  = w_clearing & w_last_cell;
    assign core_gnt    = w_gnt[0];
    assign host_gnt    = w_gnt[1];
    assign core_rvalid = r_core_rv;
    assign host_rvalid = r_host_rv;
    assign core_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_tape_arbiter.sv
// ============================================================
// tb_tape_arbiter: directed self-checking bench for tape_arbiter
// Rev 1.0
// ============================================================
`default_nettype none

module tb_tape_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_clear;
    logic       clear_busy, clear_done;
    logic       core_req, core_we, core_gnt, core_rvalid;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       host_req, host_we, host_gnt, host_rvalid;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram [256];

    always #5 clk = ~clk;

    tape_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_clear (start_clear),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Synchronous RAM model, 1-cycle read latency, pre-filled with non-zero data.
    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 8'hFF;
        mem_rdata = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Caller is positioned so that the next negedge is clear cycle 0.
    task automatic run_clear(input string name, input int pulse_at,
                             input logic rv0, input logic [7:0] rd0);
        logic [23:0] got, exp;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            start_clear = (i == pulse_at);
            #1;
            got = {mem_en, mem_we, mem_addr, mem_wdata, clear_done, clear_busy, core_gnt, host_gnt, 4'h0};
            exp = {1'b1, 1'b1, 8'(i), 8'h00, (i == 255), 1'b1, 1'b0, 1'b0, 4'h0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h required %h", name, i, got, exp);
            end
            if (i == 0) begin
                checks++;
                if (core_rvalid !== rv0 || (rv0 && core_rdata !== rd0)) begin
                    errors++;
                    $display("FAIL %s rvalid0: got rv=%b rd=%h required rv=%b rd=%h",
                             name, core_rvalid, core_rdata, rv0, rd0);
                end
            end
        end
        start_clear = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (clear_busy !== 1'b0 || clear_done !== 1'b0 || core_gnt !== core_req) begin
            errors++;
            $display("FAIL %s idle_after: got busy=%b done=%b cgnt=%b required busy=0 done=0 cgnt=%b",
                     name, clear_busy, clear_done, core_gnt, core_req);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start_clear = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({core_gnt, host_gnt, core_rvalid, host_rvalid, clear_done, mem_en, mem_we, clear_busy} !== 8'b0000_0001) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000001",
                     {core_gnt, host_gnt, core_rvalid, host_rvalid, clear_done, mem_en, mem_we, clear_busy});
        end
        core_req = 1'b0; host_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (mem_en !== 1'b0 || clear_busy !== 1'b1) begin
            errors++;
            $display("FAIL init_state: got en=%b busy=%b required en=0 busy=1", mem_en, clear_busy);
        end
    endtask

    task automatic test_initial_clear;
        run_clear("initial_clear", -1, 1'b0, 8'h00);
    endtask

    task automatic test_write_read;
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h10; core_wdata = 8'h5A;
        #1;
        checks++;
        if ({core_gnt, host_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 8'h10, 8'h5A}) begin
            errors++;
            $display("FAIL core_write: got gnt=%b en=%b we=%b a=%h d=%h required gnt=1 en=1 we=1 a=10 d=5a",
                     core_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        core_we = 1'b0; core_wdata = 8'h00;
        #1;
        checks++;
        if (core_gnt !== 1'b1 || mem_we !== 1'b0 || core_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL core_read_gnt: got gnt=%b we=%b rv=%b required gnt=1 we=0 rv=0",
                     core_gnt, mem_we, core_rvalid);
        end
        @(negedge clk);
        core_req = 1'b0;
        #1;
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 8'h5A || host_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL core_read_data: got rv=%b rd=%h hrv=%b required rv=1 rd=5a hrv=0",
                     core_rvalid, core_rdata, host_rvalid);
        end
    endtask

    task automatic test_host_read;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        #1;
        checks++;
        if (host_gnt !== 1'b1 || core_gnt !== 1'b0 || mem_addr !== 8'h20 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL host_read_gnt: got hg=%b cg=%b a=%h we=%b required hg=1 cg=0 a=20 we=0",
                     host_gnt, core_gnt, mem_addr, mem_we);
        end
        @(negedge clk);
        host_req = 1'b0;
        #1;
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'h00 || core_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL host_read_data: got rv=%b rd=%h crv=%b required rv=1 rd=00 crv=0",
                     host_rvalid, host_rdata, core_rvalid);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_cg, exp_crv, exp_hrv;
        logic [7:0] exp_rd;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
            host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
            #1;
            exp_cg  = (k % 2 == 0);
            exp_crv = (k > 0) && ((k - 1) % 2 == 0);
            exp_hrv = (k > 0) && ((k - 1) % 2 == 1);
            exp_rd  = exp_crv ? 8'h5A : 8'h00;
            checks++;
            if (core_gnt !== exp_cg || host_gnt !== ~exp_cg || core_rvalid !== exp_crv ||
                host_rvalid !== exp_hrv || (k > 0 && mem_rdata !== exp_rd)) begin
                errors++;
                $display("FAIL rr_cycle%0d: got cg=%b hg=%b crv=%b hrv=%b rd=%h required cg=%b hg=%b crv=%b hrv=%b rd=%h",
                         k, core_gnt, host_gnt, core_rvalid, host_rvalid, mem_rdata,
                         exp_cg, ~exp_cg, exp_crv, exp_hrv, exp_rd);
            end
        end
        @(negedge clk);
        core_req = 1'b0; host_req = 1'b0;
        #1;
        checks++;
        if (host_rvalid !== 1'b1 || core_rvalid !== 1'b0 || host_rdata !== 8'h00 ||
            mem_en !== 1'b0 || core_gnt !== 1'b0 || host_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rr_tail: got hrv=%b crv=%b rd=%h en=%b required hrv=1 crv=0 rd=00 en=0",
                     host_rvalid, core_rvalid, host_rdata, mem_en);
        end
    endtask

    task automatic test_clear_with_grant;
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
        start_clear = 1'b1;
        #1;
        checks++;
        if (core_gnt !== 1'b1 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_same_cycle_gnt: got gnt=%b busy=%b required gnt=1 busy=0", core_gnt, clear_busy);
        end
        run_clear("clear_held_req", -1, 1'b1, 8'h5A);
        @(negedge clk);
        core_req = 1'b0;
        #1;
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 8'h00) begin
            errors++;
            $display("FAIL post_clear_read: got rv=%b rd=%h required rv=1 rd=00", core_rvalid, core_rdata);
        end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        @(negedge clk);
        start_clear = 1'b1;
        #1;
        n = 0;
        @(negedge clk);
        start_clear = 1'b0;
        #1;
        while (mem_addr !== 8'h80 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (mem_addr !== 8'h80 || mem_en !== 1'b1) begin
            errors++;
            $display("FAIL reach_0x80: got a=%h en=%b after %0d cycles required a=80 en=1", mem_addr, mem_en, n);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (clear_busy !== 1'b1 || mem_en !== 1'b0 || clear_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b en=%b done=%b required busy=1 en=0 done=0",
                     clear_busy, mem_en, clear_done);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (mem_en !== 1'b0 || clear_busy !== 1'b1) begin
            errors++;
            $display("FAIL reinit: got en=%b busy=%b required en=0 busy=1", mem_en, clear_busy);
        end
        run_clear("restart_clear", -1, 1'b0, 8'h00);
    endtask

    task automatic test_start_mid_clear;
        @(negedge clk);
        start_clear = 1'b1;
        #1;
        run_clear("ignored_restart", 64, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_initial_clear();
        test_write_read();
        test_host_read();
        test_back_to_back();
        test_clear_with_grant();
        test_reset_mid_clear();
        test_start_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tape_arbiter.md
TAPE_ARBITER -- requirements
Module: tape_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, tape address width; tape holds 2^ADDR_W cells.
REQ-002 Parameter DATA_W, default 8, cell width.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 start_clear  in  1  one-cycle request to zero the whole tape.
REQ-007 clear_busy  out  1  high while a tape clear is in progress, including INIT.
REQ-008 clear_done  out  1  one-cycle pulse after the last cell is written.
REQ-009 core_req, core_we  in  1 each  core access request and write flag.
REQ-010 core_addr  in  ADDR_W; core_wdata  in  DATA_W.
REQ-011 core_gnt  out  1  access accepted this cycle; core_rvalid  out  1  read data valid; core_rdata  out  DATA_W.
REQ-012 host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata  same widths and meanings as the core set, for the debug/host port.
REQ-013 mem_en, mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  single-port synchronous RAM, 1-cycle read latency.

Function
REQ-014 States: INIT, CLEAR, IDLE; one state register, encoding from the package.
REQ-015 INIT -> CLEAR unconditionally; mem_en=0 in INIT.
REQ-016 CLEAR: each cycle mem_en=1, mem_we=1, mem_wdata=0, mem_addr=clear counter; counter +1 per cycle.
REQ-017 CLEAR -> IDLE after the cycle that writes address 2^ADDR_W-1; clear_done=1 on that same cycle; counter returns to 0 via wrap; total 2^ADDR_W cycles.
REQ-018 IDLE with start_clear=1 -> CLEAR next cycle with counter=0; any grant issued that same cycle completes normally.
REQ-019 start_clear in INIT or CLEAR is ignored; a clear is never restarted or extended.
REQ-020 No grants in INIT or CLEAR; requesters hold req (and stable addr/we/wdata) until gnt.
REQ-021 IDLE: at most one grant per cycle, combinational on req; granted port drives mem_en=1, mem_we, mem_addr, mem_wdata in the same cycle.
REQ-022 Single requester: granted same cycle; both requesting: round-robin, grant the port not granted most recently; pointer updates only on a grant, reset value favours core.
REQ-023 Granted read (we=0): that port's rvalid=1 exactly one cycle after gnt, rdata=mem_rdata in that cycle; rdata is don't-care otherwise.
REQ-024 Granted write: no rvalid.
REQ-025 Back-to-back grants allowed each cycle; rvalid of access N coincides with gnt of access N+1.
REQ-026 IDLE with no requests: mem_en=0.

Reset
REQ-027 While reset=0: state=INIT, clear counter=0, RR pointer=core, rvalid flags=0.
REQ-028 Output values in reset: all gnt=0, rvalid=0, clear_done=0, mem_en=0, mem_we=0, clear_busy=1.
REQ-029 Reset during CLEAR abandons it; after release a full clear restarts from address 0.

Structure
REQ-030 Package tape_pkg holds the state enumeration and default ADDR_W/DATA_W constants.
REQ-031 Two-way round-robin arbiter is a sub-module rr_arb2 (req[1:0], grant enable, gnt[1:0], internal pointer).
REQ-032 Clear counter and rvalid flags live in tape_arbiter; no other sub-modules.

Verification
REQ-033 Release reset, no requests -> clear_busy=1, 256 writes of 0 to addresses 0..255, clear_done pulse on address-255 cycle, IDLE next cycle.
REQ-034 IDLE, core write 0x5A to 0x10, then core read 0x10 -> core_gnt both cycles, core_rvalid=1 one cycle after read gnt, core_rdata=0x5A.
REQ-035 Both ports request reads continuously for 6 cycles -> grants alternate core, host, core, host, core, host; each rvalid one cycle after its gnt.
REQ-036 core_req held high and start_clear pulsed in the same IDLE cycle -> core granted that cycle; next 256 cycles clear with core_gnt=0; core granted first cycle after clear_done.
REQ-037 Reset asserted at clear address 0x80, then released -> clear restarts at 0x00 and runs 256 cycles.
REQ-038 start_clear pulsed mid-clear -> ignored; clear_done occurs exactly 256 cycles after the original start.
